// File: rtl/div32x32_pkg.sv
// Shared definitions for the sequential 32/32 unsigned divider.
package div32x32_pkg;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;

    // Iteration counter load values: full 32-bit pass and 16-bit short pass.
    localparam logic [CNT_W-1:0] CNT_FULL  = 5'd31;
    localparam logic [CNT_W-1:0] CNT_SHORT = 5'd15;

    typedef enum logic {
        IDLE = 1'b0,
        CALC = 1'b1
    } state_t;

endpackage

// File: rtl/div32x32_seq_arith.sv
// Datapath of the restoring divider: operand registers, quotient/remainder
// shift registers, the 33-bit trial subtractor and the hi-half-zero detect.
// Optional short path for small dividends: define DIV32_EARLY_EXIT_EN.
module div32x32_seq_arith
    import div32x32_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [DIV_W-1:0] i_a,
    input  logic [DIV_W-1:0] i_b,
    output logic             o_short,
    output logic [DIV_W-1:0] o_quotient,
    output logic [DIV_W-1:0] o_remainder
);

    logic [DIV_W-1:0] r_dividend;
    logic [DIV_W-1:0] r_divisor;
    logic [DIV_W-1:0] r_quotient;
    logic [DIV_W-1:0] r_remainder;
    logic [DIV_W:0]   w_trial;
    logic             w_short;

    // Bit 32 of the trial difference is the borrow: set means the divisor did not fit.
    assign w_trial = {r_remainder, r_dividend[DIV_W-1]} - {1'b0, r_divisor};

`ifdef DIV32_EARLY_EXIT_EN
    // Small dividend with a real divisor can skip the all-zero upper half.
    assign w_short = (i_a[DIV_W-1:DIV_W/2] == '0) && (i_b != '0);
`else
    assign w_short = 1'b0;
`endif

    assign o_short     = w_short;
    assign o_quotient  = r_quotient;
    assign o_remainder = r_remainder;

    // Load operands on an accepted start, then shift/subtract one bit per step.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_load) begin
            r_dividend  <= w_short ? {i_a[DIV_W/2-1:0], {(DIV_W/2){1'b0}}} : i_a;
            r_divisor   <= i_b;
            r_quotient  <= '0;
            r_remainder <= '0;
        end else if (i_step) begin
            if (!w_trial[DIV_W]) begin
                r_remainder <= w_trial[DIV_W-1:0];
            end else begin
                r_remainder <= {r_remainder[DIV_W-2:0], r_dividend[DIV_W-1]};
            end
            r_quotient <= {r_quotient[DIV_W-2:0], ~w_trial[DIV_W]};
            r_dividend <= {r_dividend[DIV_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div32x32_seq.sv
// Sequential unsigned 32/32 restoring divider, one quotient bit per clock,
// with a start/busy handshake. Define DIV32_EARLY_EXIT_EN to process only the
// low 16 dividend bits when the upper half is zero (16-cycle latency).
module div32x32_seq
    import div32x32_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DIV_W-1:0] i_a,
    input  logic [DIV_W-1:0] i_b,
    output logic             o_busy,
    output logic [DIV_W-1:0] o_quotient,
    output logic [DIV_W-1:0] o_remainder,
    output logic             o_div_by_zero
);

    state_t           r_state;
    logic [CNT_W-1:0] r_count;
    logic             r_divByZero;
    logic             w_load;
    logic             w_step;
    logic             w_short;

    assign w_load        = (r_state == IDLE) && i_start;
    assign w_step        = (r_state == CALC);
    assign o_busy        = (r_state == CALC);
    assign o_div_by_zero = r_divByZero;

    // Control FSM: accept a start in IDLE, count down iterations in CALC.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_divByZero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_count     <= w_short ? CNT_SHORT : CNT_FULL;
                        r_divByZero <= (i_b == '0);
                        r_state     <= CALC;
                    end
                end
                CALC: begin
                    if (r_count == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_count <= r_count - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    div32x32_seq_arith uArith (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_a         (i_a),
        .i_b         (i_b),
        .o_short     (w_short),
        .o_quotient  (o_quotient),
        .o_remainder (o_remainder)
    );

endmodule

// File: tb/tb_div32x32_seq.sv
// Directed self-checking bench for div32x32_seq. Expected latencies follow
// DIV32_EARLY_EXIT_EN when it is defined for the build.
module tb_div32x32_seq;

`ifdef DIV32_EARLY_EXIT_EN
    localparam int SHORT_LAT = 16;
`else
    localparam int SHORT_LAT = 32;
`endif
    localparam int FULL_LAT = 32;
    localparam int MAX_WAIT = 100;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_busy;
    logic [31:0] o_quotient;
    logic [31:0] o_remainder;
    logic        o_div_by_zero;

    int testCount;
    int failCount;

    div32x32_seq dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (i_start),
        .i_a           (i_a),
        .i_b           (i_b),
        .o_busy        (o_busy),
        .o_quotient    (o_quotient),
        .o_remainder   (o_remainder),
        .o_div_by_zero (o_div_by_zero)
    );

    // Free-running 10 ns clock.
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    // Count one comparison and report it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present operands with start for exactly one rising edge; returns 1 ns after it.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge i_clk);
        i_a     = a;
        i_b     = b;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
    endtask

    // Count edges until busy falls, bounded so a stuck DUT still reaches the summary.
    task automatic waitDone(output int cycles);
        cycles = 0;
        while (cycles < MAX_WAIT) begin
            @(posedge i_clk);
            #1;
            cycles++;
            if (!o_busy) break;
        end
    endtask

    // One complete operation checked against hand-computed results.
    task automatic runVector(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [31:0] q, input logic [31:0] r,
                             input logic dbz, input int lat);
        int cycles;
        applyStimulus(a, b);
        checkOutput({tag, " busy"}, {31'd0, o_busy}, 32'd1);
        waitDone(cycles);
        checkOutput({tag, " latency"}, cycles, lat);
        checkOutput({tag, " quotient"}, o_quotient, q);
        checkOutput({tag, " remainder"}, o_remainder, r);
        checkOutput({tag, " dbz"}, {31'd0, o_div_by_zero}, {31'd0, dbz});
    endtask

    initial begin
        int cycles;
        int partial;
        testCount = 0;
        failCount = 0;
        i_reset   = 1'b1;
        i_start   = 1'b0;
        i_a       = '0;
        i_b       = '0;
        #1;
        checkOutput("reset busy", {31'd0, o_busy}, 32'd0);
        checkOutput("reset quotient", o_quotient, 32'd0);
        checkOutput("reset remainder", o_remainder, 32'd0);
        checkOutput("reset dbz", {31'd0, o_div_by_zero}, 32'd0);
        #12;
        i_reset = 1'b0;

        runVector("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, FULL_LAT);
        runVector("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, FULL_LAT);
        runVector("3/max", 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 1'b0, SHORT_LAT);
        runVector("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, FULL_LAT);
        runVector("1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, SHORT_LAT);
        runVector("65536/3", 32'h0001_0000, 32'd3, 32'd21845, 32'd1, 1'b0, FULL_LAT);
        runVector("65535/16", 32'h0000_FFFF, 32'd16, 32'd4095, 32'd15, 1'b0, SHORT_LAT);

        // A start pulse mid-operation must not disturb the running divide.
        applyStimulus(32'd100, 32'd7);
        repeat (4) begin
            @(posedge i_clk);
            #1;
        end
        i_a     = 32'd9;
        i_b     = 32'd2;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        waitDone(partial);
        checkOutput("ignored start latency", 5 + partial, FULL_LAT);
        checkOutput("ignored start quotient", o_quotient, 32'd14);
        checkOutput("ignored start remainder", o_remainder, 32'd2);

        // Async reset mid-operation discards the in-flight result immediately.
        applyStimulus(32'hFFFF_FFFF, 32'd0);
        repeat (10) begin
            @(posedge i_clk);
            #1;
        end
        checkOutput("pre-reset dbz", {31'd0, o_div_by_zero}, 32'd1);
        checkOutput("pre-reset quotient", o_quotient, 32'h0000_03FF);
        #2;
        i_reset = 1'b1;
        #1;
        checkOutput("mid reset busy", {31'd0, o_busy}, 32'd0);
        checkOutput("mid reset quotient", o_quotient, 32'd0);
        checkOutput("mid reset remainder", o_remainder, 32'd0);
        checkOutput("mid reset dbz", {31'd0, o_div_by_zero}, 32'd0);
        @(negedge i_clk);
        i_reset = 1'b0;
        runVector("post reset 1000/3", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, SHORT_LAT);

        // Back-to-back: start held across completion launches the next divide at once.
        @(negedge i_clk);
        i_a     = 32'd100;
        i_b     = 32'd7;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_a = 32'd50;
        i_b = 32'd5;
        waitDone(cycles);
        checkOutput("b2b first latency", cycles, FULL_LAT);
        checkOutput("b2b first quotient", o_quotient, 32'd14);
        checkOutput("b2b first remainder", o_remainder, 32'd2);
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        checkOutput("b2b second busy", {31'd0, o_busy}, 32'd1);
        waitDone(cycles);
        checkOutput("b2b second latency", cycles, SHORT_LAT);
        checkOutput("b2b second quotient", o_quotient, 32'd10);
        checkOutput("b2b second remainder", o_remainder, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
